// File: rtl/speles_logika_param_if.sv
// speles_logika_param_if: player-side signal bundle of the guessing-game controller.
// The game controller takes the slave view; whatever drives the buttons and the
// comparator and watches the status takes the master view.
interface speles_logika_param_if #(
    parameter int LEVEL_W = 8,
    parameter int VAL_W   = 5
);
    logic               guess_b;
    logic               cmp_r;
    logic               end_f;
    logic [2:0]         state;
    logic [LEVEL_W-1:0] level;
    logic               set_f;
    logic [VAL_W-1:0]   set_v;
    logic [3:0]         tries_left;
    logic               win_f;
    logic               lose_f;

    modport master (
        output guess_b, cmp_r, end_f,
        input  state, level, set_f, set_v, tries_left, win_f, lose_f
    );

    modport slave (
        input  guess_b, cmp_r, end_f,
        output state, level, set_f, set_v, tries_left, win_f, lose_f
    );
endinterface

// File: rtl/speles_logika_param.sv
// speles_logika_param: number-guessing game controller.
// A free-running maximal-length LFSR supplies each level's target value; the player
// gets MAX_TRIES wrong guesses per level and must clear NUM_LEVELS levels.
// Optional build macro: GUESS_TIMEOUT_EN -- when defined, sitting in GUESS for
// TIMEOUT_CYC cycles without a guess counts as a wrong guess.
module speles_logika_param #(
    parameter int LEVEL_W     = 8,
    parameter int VAL_W       = 5,
    parameter int MAX_TRIES   = 3,
    parameter int NUM_LEVELS  = 4,
    parameter int SEED        = 1,
    parameter int TIMEOUT_CYC = 1000
) (
    input logic                  clk,
    input logic                  rst,
    speles_logika_param_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        GUESS = 3'd2,
        CHECK = 3'd3,
        WIN   = 3'd4,
        LOSE  = 3'd5,
        DONE  = 3'd6
    } state_t;

    // Feedback taps (bit n-1 and k-1 for polynomial x^n + x^k + ...); SEED must be nonzero.
    localparam logic [7:0] TAPS8 = (VAL_W == 3) ? 8'h06 :
                                   (VAL_W == 4) ? 8'h0C :
                                   (VAL_W == 5) ? 8'h14 :
                                   (VAL_W == 6) ? 8'h30 :
                                   (VAL_W == 7) ? 8'h60 : 8'hB8;
    localparam logic [VAL_W-1:0]   TAPS      = TAPS8[VAL_W-1:0];
    localparam logic [LEVEL_W-1:0] LEVEL_TOP = LEVEL_W'(NUM_LEVELS);
    localparam logic [3:0]         TRIES_INI = 4'(MAX_TRIES);

    state_t             state_q, state_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [VAL_W-1:0]   set_v_q, set_v_d;
    logic [VAL_W-1:0]   lfsr_q, lfsr_d;
    logic [3:0]         tries_q, tries_d;
    logic               set_f_q, set_f_d;
    logic               win_f_q, win_f_d;
    logic               lose_f_q, lose_f_d;
    logic               guess_q;
    logic               guess_p;
    logic               cmp_hit;

    assign guess_p = bus.guess_b & ~guess_q;
    assign lfsr_d  = {lfsr_q[VAL_W-2:0], ^(lfsr_q & TAPS)};

`ifdef GUESS_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            to_q, to_d;

    // A timed-out guess reaches CHECK as a miss regardless of the comparator.
    assign cmp_hit = bus.cmp_r & ~to_q;

    // Idle counter for the GUESS timeout and the flag marking a timed-out CHECK.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= to_d;
        end
    end
`else
    logic unused_timeout;

    assign cmp_hit        = bus.cmp_r;
    assign unused_timeout = ^32'(TIMEOUT_CYC);
`endif

    // Next-state and datapath decisions; abort beats every other event.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        set_v_d = set_v_q;
        tries_d = tries_q;
`ifdef GUESS_TIMEOUT_EN
        cnt_d   = '0;
        to_d    = 1'b0;
`endif
        if (bus.end_f) begin
            state_d = IDLE;
            level_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    level_d = '0;
                    if (guess_p) begin
                        state_d = LOAD;
                        set_v_d = lfsr_q;
                        tries_d = TRIES_INI;
                    end
                end
                LOAD: state_d = GUESS;
                GUESS: begin
`ifdef GUESS_TIMEOUT_EN
                    if (guess_p) begin
                        state_d = CHECK;
                    end else if (cnt_q == TO_LAST) begin
                        state_d = CHECK;
                        to_d    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`else
                    if (guess_p) begin
                        state_d = CHECK;
                    end
`endif
                end
                CHECK: begin
                    if (cmp_hit) begin
                        state_d = WIN;
                        if (level_q != LEVEL_TOP) begin
                            level_d = level_q + 1'b1;
                        end
                    end else if (tries_q > 4'd1) begin
                        state_d = GUESS;
                        tries_d = tries_q - 1'b1;
                    end else begin
                        state_d = LOSE;
                        tries_d = 4'd0;
                    end
                end
                WIN: begin
                    if (level_q == LEVEL_TOP) begin
                        state_d = DONE;
                    end else if (guess_p) begin
                        state_d = LOAD;
                        set_v_d = lfsr_q;
                        tries_d = TRIES_INI;
                    end
                end
                LOSE, DONE: begin
                    if (guess_p) begin
                        state_d = IDLE;
                        level_d = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    level_d = '0;
                end
            endcase
        end
        set_f_d  = (state_d == LOAD);
        win_f_d  = (state_d == WIN) || (state_d == DONE);
        lose_f_d = (state_d == LOSE);
    end

    // Game state, registered status outputs, LFSR and button history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            level_q  <= '0;
            set_v_q  <= '0;
            tries_q  <= '0;
            set_f_q  <= 1'b0;
            win_f_q  <= 1'b0;
            lose_f_q <= 1'b0;
            lfsr_q   <= VAL_W'(SEED);
            guess_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            set_v_q  <= set_v_d;
            tries_q  <= tries_d;
            set_f_q  <= set_f_d;
            win_f_q  <= win_f_d;
            lose_f_q <= lose_f_d;
            lfsr_q   <= lfsr_d;
            guess_q  <= bus.guess_b;
        end
    end

    assign bus.state      = state_q;
    assign bus.level      = level_q;
    assign bus.set_f      = set_f_q;
    assign bus.set_v      = set_v_q;
    assign bus.tries_left = tries_q;
    assign bus.win_f      = win_f_q;
    assign bus.lose_f     = lose_f_q;
endmodule
